// File: rtl/mult_acc_serializer_pkg.sv
// Shared types and the saturating add used by the product accumulator.
// Widths up to ACC_MAX_W are supported by the helper.
package mult_pkg;

   typedef enum logic {ACCUM, SEND} state_e;

   localparam int PROD_W    = 8;
   localparam int ACC_MAX_W = 64;

   typedef struct packed {
      logic                 ovf;
      logic [ACC_MAX_W-1:0] sum;
   } sat_t;

   // Adds an unsigned product to an acc_w-bit accumulator, clamping at 2^acc_w-1.
   function automatic sat_t sat_add(input logic [ACC_MAX_W-1:0] acc,
                                    input logic [PROD_W-1:0]    prod,
                                    input int                   acc_w);
      logic [ACC_MAX_W:0] sum;
      logic [ACC_MAX_W:0] lim;
      sat_t               r;
      sum   = {1'b0, acc} + {{(ACC_MAX_W+1-PROD_W){1'b0}}, prod};
      lim   = ({{ACC_MAX_W{1'b0}}, 1'b1} << acc_w) - {{ACC_MAX_W{1'b0}}, 1'b1};
      r.ovf = (sum > lim);
      r.sum = r.ovf ? lim[ACC_MAX_W-1:0] : sum[ACC_MAX_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/mult_acc_serializer_byte_serializer.sv
// Loads a wide word and emits it LSB-byte-first over a valid/ready/last byte stream.
// done pulses on the handshake of the final byte.
module byte_serializer
   import mult_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [ACC_W-1:0]  load_data,
   output logic              out_valid,
   output logic [PROD_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              done
);

   localparam int NBYTES = ACC_W / PROD_W;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   logic [ACC_W-1:0] sreg_q, sreg_d;
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic             valid_q, valid_d;

   assign out_valid = valid_q;
   assign out_data  = sreg_q[PROD_W-1:0];
   assign out_last  = valid_q && (byte_idx_q == IDX_LAST);
   assign done      = out_last && out_ready && !clear;

   always_comb begin
      sreg_d     = sreg_q;
      byte_idx_d = byte_idx_q;
      valid_d    = valid_q;
      if (clear) begin
         byte_idx_d = '0;
         valid_d    = 1'b0;
      end else if (load) begin
         sreg_d     = load_data;
         byte_idx_d = '0;
         valid_d    = 1'b1;
      end else if (valid_q && out_ready) begin
         sreg_d     = sreg_q >> PROD_W;
         byte_idx_d = byte_idx_q + IDX_W'(1);
         if (out_last) begin
            byte_idx_d = '0;
            valid_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q     <= '0;
         byte_idx_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         sreg_q     <= sreg_d;
         byte_idx_q <= byte_idx_d;
         valid_q    <= valid_d;
      end
   end

endmodule

// File: rtl/mult_acc_serializer.sv
// Sums COUNT multiplier products with saturation and streams each sum out
// LSB byte first; products are back-pressured while a result is being sent.
module mult_acc_serializer
   import mult_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int COUNT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_in,
   output logic              prod_ready,
   output logic              out_valid,
   output logic [PROD_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              ovf
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             run_q;
   logic             accept;
   logic             load;
   logic             ser_done;
   logic [ACC_W-1:0] sum_sat;
   sat_t             sat_r;

   // run_q keeps prod_ready low until the first edge after reset release.
   assign prod_ready = run_q && (state_q == ACCUM) && !clear;
   assign accept     = prod_valid && prod_ready;
   assign ovf        = ovf_q;

   always_comb begin
      sat_r   = sat_add(ACC_MAX_W'(acc_q), prod_in, ACC_W);
      sum_sat = ACC_W'(sat_r.sum);
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      load    = 1'b0;
      if (clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_d = sum_sat;
                  ovf_d = ovf_q | sat_r.ovf;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     load    = 1'b1;
                     state_d = SEND;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            SEND: begin
               if (ser_done) begin
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ACCUM;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         run_q   <= 1'b1;
      end
   end

   byte_serializer #(.ACC_W(ACC_W)) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .load      (load),
      .load_data (sum_sat),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_mult_acc_serializer.sv
// Scoreboard bench: three instances (COUNT=4, COUNT=255, COUNT=258 for saturation)
// share clock, reset, clear, prod_in and out_ready; each has its own prod_valid.
module tb_mult_acc_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] prod_in = 8'd0;
   logic [2:0] pv = 3'b000;
   logic [2:0] pr, ov, ol, of;
   logic [7:0] od [3];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
      logic       last;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   mult_acc_serializer #(.ACC_W(16), .COUNT(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(pv[0]), .prod_in(prod_in),
      .prod_ready(pr[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
      .out_ready(out_ready), .ovf(of[0]));

   mult_acc_serializer #(.ACC_W(16), .COUNT(255)) dut_c255 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(pv[1]), .prod_in(prod_in),
      .prod_ready(pr[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
      .out_ready(out_ready), .ovf(of[1]));

   mult_acc_serializer #(.ACC_W(16), .COUNT(258)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(pv[2]), .prod_in(prod_in),
      .prod_ready(pr[2]), .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]),
      .out_ready(out_ready), .ovf(of[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int c, input logic [7:0] d, input logic last, input logic ovf_e);
      exp_t e;
      e.ch   = 2'(c);
      e.data = d;
      e.last = last;
      e.ovf  = ovf_e;
      exp_q.push_back(e);
   endtask

   // Drives one product on channel c and returns 1 time unit after it is accepted.
   task automatic send(input int c, input logic [7:0] v);
      int   n  = 0;
      logic ok = 1'b0;
      pv[c]   = 1'b1;
      prod_in = v;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = pr[c];
         n++;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout ch%0d: prod_ready stayed 0, required 1", c);
         pv[c] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      pv[c] = 1'b0;
   endtask

   task automatic wait_drain(input int c);
      int n = 0;
      while ((exp_q.size() != 0 || ov[c]) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("drain_ch%0d_pending", c), exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expected byte per handshake; clear/reset abandon pending bytes.
   always @(negedge clk) begin
      if (!rst_n || clear) begin
         exp_q.delete();
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (ov[c]) begin
               if (exp_q.size() == 0 || int'(exp_q[0].ch) != c) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte ch%0d: got data 0x%0h last %0b, required no output",
                           c, od[c], ol[c]);
               end else begin
                  check($sformatf("out_data_ch%0d", c), 32'(od[c]), 32'(exp_q[0].data));
                  check($sformatf("out_last_ch%0d", c), 32'(ol[c]), 32'(exp_q[0].last));
                  check($sformatf("ovf_ch%0d", c), 32'(of[c]), 32'(exp_q[0].ovf));
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #2;
      check("rst_out_valid", 32'(ov[0]), 0);
      check("rst_out_data", 32'(od[0]), 0);
      check("rst_out_last", 32'(ol[0]), 0);
      check("rst_prod_ready", 32'(pr[0]), 0);
      check("rst_ovf", 32'(of[0]), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("prod_ready_before_first_edge", 32'(pr[0]), 0);
      @(posedge clk);
      #1;
      check("prod_ready_after_first_edge", 32'(pr[0]), 1);

      // Basic sum: 4 x 225 = 900 = 0x0384
      out_ready = 1'b1;
      push(0, 8'h84, 1'b0, 1'b0);
      push(0, 8'h03, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 8'd225);
      wait_drain(0);
      check("basic_ovf_after", 32'(of[0]), 0);

      // Back-pressure for 5 cycles
      out_ready = 1'b0;
      push(0, 8'h84, 1'b0, 1'b0);
      push(0, 8'h03, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 8'd225);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_prod_ready", 32'(pr[0]), 0);
         check("bp_out_valid", 32'(ov[0]), 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain(0);

      // Gaps between products: 1+0+2+3 = 6
      push(0, 8'h06, 1'b0, 1'b0);
      push(0, 8'h00, 1'b1, 1'b0);
      send(0, 8'd1); @(posedge clk); #1;
      send(0, 8'd0); @(posedge clk); #1;
      send(0, 8'd2); @(posedge clk); #1;
      send(0, 8'd3);
      wait_drain(0);

      // Clear after 2 of 4, then 10+20+30+40 = 100
      send(0, 8'd7);
      send(0, 8'd9);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      push(0, 8'h64, 1'b0, 1'b0);
      push(0, 8'h00, 1'b1, 1'b0);
      send(0, 8'd10);
      send(0, 8'd20);
      send(0, 8'd30);
      send(0, 8'd40);
      wait_drain(0);

      // Clear in the first SEND cycle with out_ready high: result abandoned
      for (int i = 0; i < 4; i++) send(0, 8'd1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("clear_send_out_valid", 32'(ov[0]), 0);
      check("clear_send_out_last", 32'(ol[0]), 0);
      push(0, 8'h0A, 1'b0, 1'b0);
      push(0, 8'h00, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      send(0, 8'd1);
      send(0, 8'd2);
      send(0, 8'd3);
      send(0, 8'd4);
      wait_drain(0);

      // Async reset mid-SEND
      out_ready = 1'b0;
      push(0, 8'h0A, 1'b0, 1'b0);
      push(0, 8'h00, 1'b1, 1'b0);
      send(0, 8'd1);
      send(0, 8'd2);
      send(0, 8'd3);
      send(0, 8'd4);
      @(negedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(ov[0]), 0);
      check("async_rst_out_data", 32'(od[0]), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push(0, 8'h14, 1'b0, 1'b0);
      push(0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 8'd5);
      wait_drain(0);

      // COUNT=255: 255 x 255 = 65025 = 0xFE01, no saturation
      push(1, 8'h01, 1'b0, 1'b0);
      push(1, 8'hFE, 1'b1, 1'b0);
      for (int i = 0; i < 255; i++) send(1, 8'hFF);
      wait_drain(1);

      // COUNT=258: 257 x 255 = 65535 exactly, then the 258th clamps
      push(2, 8'hFF, 1'b0, 1'b1);
      push(2, 8'hFF, 1'b1, 1'b1);
      for (int i = 0; i < 257; i++) send(2, 8'hFF);
      check("sat_exact_max_ovf", 32'(of[2]), 0);
      send(2, 8'hFF);
      wait_drain(2);
      check("sat_ovf_after_last", 32'(of[2]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
